muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int XLEN = 32;  // operand and HI/LO width
  localparam int ITER = 32;  // iterations per operation

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Encoding bit 0 distinguishes unsigned (1) from signed (0) variants.
  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

  // Encoding bit 1 distinguishes divide (1) from multiply (0).
  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add for multiply, restoring shift-subtract for divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: is_div selects the operation; acc_hi/acc_lo is the running accumulator
//        (multiply: partial product / remaining multiplier bits,
//         divide: partial remainder / dividend-then-quotient bits);
//        operand is the multiplicand or divisor magnitude; nxt_hi/nxt_lo is the updated accumulator.
module muldiv_step #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {XLEN{1'b0}})};
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, operand};

    // Multiply: add-or-pass, then shift the whole accumulator right so the
    // carry lands in the top bit and the consumed multiplier bit drops out.
    nxt_hi = sum[XLEN:1];
    nxt_lo = {sum[0], acc_lo[XLEN-1:1]};

    if (is_div) begin
      // Divide: a negative difference means restore; the remainder stays
      // below the divisor, so a non-negative difference always fits XLEN bits.
      if (diff[XLEN+1]) begin
        nxt_hi = shifted[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end else begin
        nxt_hi = diff[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Latency: done pulses in the cycle after the 35th edge following the accepting edge (ITER=32).
// Backpressure: busy is high outside IDLE; start while busy is dropped, not queued.
// Ports: clk/rst_n (sync, active-low); start/op/Op1/Op2 request; flush aborts;
//        hi_we/lo_we/wdata are MTHI/MTLO; busy/done status; HI/LO results;
//        div_by_zero flags a zero divisor on the last completed divide.
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN,
  parameter int ITER = muldiv_pkg::ITER
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] Op1,
  input  logic [XLEN-1:0] Op2,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            div_by_zero
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITER + 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] op1_q, op1_d;      // raw dividend, returned in HI on divide-by-zero
  logic [XLEN-1:0] b_q, b_d;          // Op2 raw, then its magnitude after PREP
  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;      // product/quotient sign
  logic            rneg_q, rneg_d;    // remainder sign follows the dividend
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            dbz_q, dbz_d;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (b_q),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    op1_d    = op1_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    a_neg    = op_is_signed(op_q) & op1_q[XLEN-1];
    b_neg    = op_is_signed(op_q) & b_q[XLEN-1];
    prod     = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quo      = neg_q ? -acc_lo_q : acc_lo_q;
    rem      = rneg_q ? -acc_hi_q : acc_hi_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          op_d    = op_e'(op);
          op1_d   = Op1;
          b_d     = Op2;
          dbz_d   = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // Multiply reuses the same layout: Op1 magnitude is the multiplier
        // in acc_lo, Op2 magnitude the multiplicand (product is commutative).
        acc_hi_d = '0;
        acc_lo_d = a_neg ? -op1_q : op1_q;
        b_d      = b_neg ? -b_q : b_q;
        neg_d    = a_neg ^ b_neg;
        rneg_d   = a_neg;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // Iterations run while cnt < ITER; the cycle that sees cnt == ITER
        // only hands over to FIX.
        if (cnt_q == CW'(ITER)) begin
          state_d = S_FIX;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
        if (!op_is_div(op_q)) begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else if (b_q == '0) begin
          hi_d  = op1_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort leaves architectural state exactly as it was.
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      op1_q    <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected HI/LO/flag,
// a negedge monitor pops one entry per done pulse and compares.
// Also covers latency, flush, ignored start/MTHI while busy, and reset mid-run.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Op1, Op2;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] HI, LO;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .Op1         (Op1),
    .Op2         (Op2),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .HI          (HI),
    .LO          (LO),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_hi", 64'(HI), 64'(e.hi));
        check("sb_lo", 64'(LO), 64'(e.lo));
        check("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Drive one start cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; Op1 = a; Op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    Op1 = $urandom; Op2 = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
    int cyc;
    bit seen;
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed;
    exp_q.push_back(e);
    issue(o, a, b);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({nm, "_flag_clr"}, 64'(div_by_zero), 64'd0);
      if (done) seen = 1;
    end
    // done first visible after the 35th edge past the accepting edge = 36th negedge.
    check({nm, "_latency"}, 64'(cyc), 64'd36);
    @(negedge clk);
    check({nm, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    int d0;
    int cyc;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; Op1 = '0; Op2 = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // MTHI / MTLO in IDLE
    @(posedge clk); #1; hi_we = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0;
    @(posedge clk); #1; lo_we = 1'b0;
    @(negedge clk);
    check("mthi", 64'(HI), 64'h12345678);
    check("mtlo", 64'(LO), 64'h9ABCDEF0);

    // Directed arithmetic vectors
    do_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op("mult_min2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    do_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    do_op("divu_zero", 2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    do_op("divu_after", 2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);
    do_op("div_zero_s", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    do_op("div_pos", 2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);
    // HI=2, LO=FFFFFFF2 from here on

    // Flush ten cycles after start: no done, HI/LO held
    d0 = done_cnt;
    issue(2'b01, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(HI), 64'h00000002);
    check("flush_lo", 64'(LO), 64'hFFFFFFF2);
    repeat (50) @(negedge clk);
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);

    // flush and start together in IDLE: start dropped
    @(posedge clk); #1; start = 1'b1; flush = 1'b1; op = 2'b01; Op1 = 32'd1; Op2 = 32'd1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(busy), 64'd0);

    // start and MTHI while busy are ignored
    begin
      exp_t e;
      e.hi = 32'h0; e.lo = 32'd42; e.dbz = 1'b0;
      exp_q.push_back(e);
    end
    d0 = done_cnt;
    issue(2'b01, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1; start = 1'b1; op = 2'b11; Op1 = 32'd9; Op2 = 32'd3; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    check("busy_hi_we", 64'(HI), 64'h00000002);
    cyc = 0;
    while (done_cnt == d0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_op_done", 64'(done_cnt - d0), 64'd1);
    repeat (50) @(negedge clk);
    check("busy_start_dropped", 64'(done_cnt - d0), 64'd1);

    // Reset during RUN
    d0 = done_cnt;
    issue(2'b11, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1; rst_n = 1'b0; flush = 1'b1; hi_we = 1'b1; wdata = 32'h55555555;
    @(posedge clk); #1; rst_n = 1'b1; flush = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    check("rrun_busy", 64'(busy), 64'd0);
    check("rrun_hi", 64'(HI), 64'd0);
    check("rrun_lo", 64'(LO), 64'd0);
    repeat (50) @(negedge clk);
    check("rrun_no_done", 64'(done_cnt - d0), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
